ex_muldiv_sequencer: RTL and testbench
======================================

Name: ex_muldiv_sequencer

Overview:
- Iterative multiply/divide unit and HI/LO register owner, attached alongside the EX-stage ALU.
- Takes the same rs/rt operands as the ALU and runs a 32-iteration shift-add multiply or restoring divide.
- Drives a stall request to hold the pipeline while busy, then writes HI/LO.
- Supports abort when CP0 flushes the instruction, e.g. on an ex_overflow exception.

Parameters:
DIV_BY_ZERO_LO, 32'hFFFFFFFF, value written to LO on divide by zero (HI receives the dividend).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
mdStart  input  1  EX-stage instruction is a mul/div/MTHI/MTLO; sampled with mdOperation.
mdOperation  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op.
operandA  input  32  rs value, already forwarded.
operandB  input  32  rt value, already forwarded.
cancel  input  1  CP0 flush; aborts the current or starting operation.
mdBusy  output  1  stall request to the hazard unit.
mdDone  output  1  one-cycle pulse: HI/LO updated by a mul/div.
hi  output  32  HI register.
lo  output  32  LO register.

Behaviour:
- Reset, asynchronous while rst_n=0:
  - state=IDLE, counter=0, hi=0, lo=0, mdBusy=0, mdDone=0.
  - Internal operand and accumulator registers are cleared.
  - Reset during RUN or FIX abandons the operation.
- States: IDLE, RUN, FIX.
- IDLE:
  - MUL/DIV start: if mdStart=1, cancel=0 and op is 00x/01x in cycle C0, latch the operands at the C0 edge.
    - Signed ops latch operand magnitudes plus the result sign flags: product sign = signA^signB; quotient sign = signA^signB; remainder sign = signA.
    - Next state is RUN with counter=31, except DIV/DIVU with operandB=0, which goes directly to FIX.
  - MTHI / MTLO with mdStart=1 and cancel=0: hi (resp. lo) takes operandA at the C0 edge. Single cycle; no mdBusy, no mdDone.
  - Op 11x, or cancel=1: no state or register change.
- RUN:
  - Multiply: one shift-add per cycle on a 64-bit accumulator.
  - Divide: one restoring subtract-shift per cycle; 33-bit remainder, 32-bit quotient.
  - Counter decrements each cycle; when counter=0, next state is FIX. RUN occupies C1..C32.
- FIX (C33):
  - Apply two's-complement sign correction to the magnitude results.
  - Write hi/lo at the end of the cycle:
    - Multiply: hi = product[63:32], lo = product[31:0].
    - Divide: lo = quotient, hi = remainder.
  - Next state is IDLE.
- Divide by zero: FIX in C1 with lo=DIV_BY_ZERO_LO and hi=operandA, unmodified by any sign rule.
- Signed overflow case, DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This falls out of magnitude arithmetic; no special path.
- mdBusy is combinational:
  - 1 when state!=IDLE.
  - 1 in IDLE when mdStart and cancel=0 and op is 00x/01x.
  - So the pipeline stalls from C0 through C33 and releases in C34.
- mdDone is registered: high for exactly the one cycle following FIX (C34 for normal ops, C2 for divide by zero). hi/lo hold the new values in that cycle.
- cancel=1 while in RUN or FIX: next state is IDLE, hi/lo are unchanged, no mdDone. mdBusy stays 1 for the remainder of that cycle.
- mdStart while state!=IDLE is ignored; the stalled pipeline must hold it until mdBusy falls, and it is not queued.
- hi/lo change only at a FIX completion or an MTHI/MTLO; they are stable during RUN.
- A back-to-back start in the same cycle as mdDone is accepted (state is IDLE).

Test Plan:
- MULT operandA=0xFFFFFFFD (-3), operandB=7 -> mdBusy high C0..C33; mdDone in C34 with hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; signed MULT of the same operands -> hi=0, lo=1.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 10 / 0 -> mdBusy C0..C1, mdDone in C2, lo=0xFFFFFFFF, hi=0x0000000A.
- Preload via MTHI 0x11111111 and MTLO 0x22222222 (no mdBusy). Then:
  - MULT 5x5 with cancel pulsed in C10 -> IDLE in C11, no mdDone, hi/lo remain 0x11111111 / 0x22222222.
  - Repeat with rst_n low in C20 -> hi=lo=0 and mdBusy=0 immediately.

Source files
------------

// File: rtl/ex_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// ex_muldiv_sequencer
//
// Purpose:
//   Iterative multiply/divide unit that owns the HI/LO registers. It sits
//   beside the EX-stage ALU and takes the same forwarded rs/rt operands.
//   MULT/MULTU use a 32-step shift-add multiply. DIV/DIVU use a 32-step
//   restoring divide. Both work on operand magnitudes, and the sign is
//   corrected in a final FIX cycle. MTHI/MTLO write HI/LO in one cycle.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   mdStart      in   EX instruction is a mul/div/MTHI/MTLO
//   mdOperation  in   000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//                     100 MTHI, 101 MTLO, 11x no-op
//   operandA     in   rs value (forwarded)
//   operandB     in   rt value (forwarded)
//   cancel       in   CP0 flush; aborts the current or starting operation
//   mdBusy       out  stall request to the hazard unit (combinational)
//   mdDone       out  one-cycle pulse after HI/LO were updated by a mul/div
//   hi, lo       out  HI and LO registers
//   state_dbg    out  current FSM state (0 IDLE, 1 RUN, 2 FIX) for observation
//
// Handshake:
//   An operation is accepted on the rising edge that ends a cycle in which
//   state is IDLE, mdStart=1, cancel=0 and mdOperation is 00x/01x.
//   mdBusy is raised in that same cycle and stays high until FIX completes,
//   so the pipeline holds the instruction in EX. mdStart is ignored while
//   the FSM is not IDLE, and it is not queued.
// ---------------------------------------------------------------------------
module ex_muldiv_sequencer #(
   parameter logic [31:0] DIV_BY_ZERO_LO = 32'hFFFFFFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mdStart,
   input  logic [2:0]  mdOperation,
   input  logic [31:0] operandA,
   input  logic [31:0] operandB,
   input  logic        cancel,
   output logic        mdBusy,
   output logic        mdDone,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t      state;
   logic [4:0]  counter;
   logic        is_div;     // latched operation class: 1 divide, 0 multiply
   logic        dbz;        // divide by zero; FIX takes the bypass path
   logic        neg_q;      // negate the product or quotient in FIX
   logic        neg_r;      // negate the remainder in FIX
   logic [31:0] opnd_b;     // multiplicand or divisor magnitude
   logic [63:0] acc;        // multiply: {partial product, remaining multiplier}
   logic [31:0] rem;        // divide: partial remainder
   logic [31:0] quot;       // divide: dividend bits shifted out, quotient shifted in

   // ---------------------------------------------------------------------
   // Operand decode and magnitudes
   // ---------------------------------------------------------------------
   logic        signed_op;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic        start_md;

   // The LSB of mdOperation selects unsigned (MULTU/DIVU).
   assign signed_op = ~mdOperation[0];
   assign a_neg     = signed_op & operandA[31];
   assign b_neg     = signed_op & operandB[31];
   assign a_mag     = a_neg ? (32'd0 - operandA) : operandA;
   assign b_mag     = b_neg ? (32'd0 - operandB) : operandB;

   assign start_md  = (state == IDLE) & mdStart & ~cancel & ~mdOperation[2];
   assign mdBusy    = (state != IDLE) | start_md;
   assign state_dbg = state;

   // ---------------------------------------------------------------------
   // One multiply step: add the multiplicand if the multiplier LSB is set,
   // then shift the whole accumulator right by one.
   // ---------------------------------------------------------------------
   logic [32:0] mul_sum;

   assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd_b} : 33'd0);

   // ---------------------------------------------------------------------
   // One restoring divide step. The shifted remainder is below twice the
   // divisor, so it fits in 33 bits. Bit 32 of the 33-bit difference is
   // therefore the borrow.
   // ---------------------------------------------------------------------
   logic [32:0] div_shift;
   logic [32:0] div_diff;
   logic        div_ok;

   assign div_shift = {rem, quot[31]};
   assign div_diff  = div_shift - {1'b0, opnd_b};
   assign div_ok    = ~div_diff[32];

   // ---------------------------------------------------------------------
   // Sign correction applied in FIX
   // ---------------------------------------------------------------------
   logic [63:0] prod_fix;
   logic [31:0] quot_fix;
   logic [31:0] rem_fix;

   assign prod_fix = neg_q ? (64'd0 - acc)  : acc;
   assign quot_fix = neg_q ? (32'd0 - quot) : quot;
   assign rem_fix  = neg_r ? (32'd0 - rem)  : rem;

   // ---------------------------------------------------------------------
   // FSM and datapath registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         counter <= 5'd0;
         is_div  <= 1'b0;
         dbz     <= 1'b0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         opnd_b  <= 32'd0;
         acc     <= 64'd0;
         rem     <= 32'd0;
         quot    <= 32'd0;
         hi      <= 32'd0;
         lo      <= 32'd0;
         mdDone  <= 1'b0;
      end else begin
         mdDone <= 1'b0;
         case (state)
            IDLE: begin
               if (mdStart && !cancel) begin
                  if (!mdOperation[2]) begin
                     is_div  <= mdOperation[1];
                     neg_q   <= a_neg ^ b_neg;
                     neg_r   <= a_neg;
                     opnd_b  <= b_mag;
                     acc     <= {32'd0, a_mag};
                     rem     <= 32'd0;
                     counter <= 5'd31;
                     if (mdOperation[1] && (operandB == 32'd0)) begin
                        // Divide by zero skips RUN. quot carries the raw
                        // dividend so that FIX can copy it into HI.
                        dbz   <= 1'b1;
                        quot  <= operandA;
                        state <= FIX;
                     end else begin
                        dbz   <= 1'b0;
                        quot  <= a_mag;
                        state <= RUN;
                     end
                  end else if (mdOperation[1:0] == 2'b00) begin
                     hi <= operandA;
                  end else if (mdOperation[1:0] == 2'b01) begin
                     lo <= operandA;
                  end
               end
            end

            RUN: begin
               if (cancel) begin
                  state <= IDLE;
               end else begin
                  if (is_div) begin
                     rem  <= div_ok ? div_diff[31:0] : div_shift[31:0];
                     quot <= {quot[30:0], div_ok};
                  end else begin
                     acc <= {mul_sum, acc[31:1]};
                  end
                  if (counter == 5'd0) begin
                     state <= FIX;
                  end else begin
                     counter <= counter - 5'd1;
                  end
               end
            end

            FIX: begin
               state <= IDLE;
               if (!cancel) begin
                  mdDone <= 1'b1;
                  if (dbz) begin
                     hi <= quot;
                     lo <= DIV_BY_ZERO_LO;
                  end else if (is_div) begin
                     hi <= rem_fix;
                     lo <= quot_fix;
                  end else begin
                     hi <= prod_fix[63:32];
                     lo <= prod_fix[31:0];
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Testbench for ex_muldiv_sequencer. Expected HI/LO pairs come from an
// arithmetic model in the bench. They are pushed to exp_q when an operation
// is driven, and popped when mdDone pulses.
module tb_ex_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mdStart;
  logic [2:0]  mdOperation;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic        cancel;
  logic        mdBusy;
  logic        mdDone;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  logic [63:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  ex_muldiv_sequencer dut (
    .clk(clk),
    .rst_n(rst_n),
    .mdStart(mdStart),
    .mdOperation(mdOperation),
    .operandA(operandA),
    .operandB(operandB),
    .cancel(cancel),
    .mdBusy(mdBusy),
    .mdDone(mdDone),
    .hi(hi),
    .lo(lo),
    .state_dbg(state_dbg)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp_v);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p = 64'd0;
    case (op[1:0])
      2'b00: begin
        p = sa * sb;
      end
      2'b01: begin
        p = {32'd0, a} * {32'd0, b};
      end
      2'b10: begin
        if (b == 32'd0) p = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) p = {a, 32'hFFFFFFFF};
        else p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && mdDone) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        check("sb_unexpected_done", {63'd0, mdDone}, 64'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("sb_hi", {32'd0, hi}, {32'd0, e[63:32]});
        check("sb_lo", {32'd0, lo}, {32'd0, e[31:0]});
      end
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int exp_lat);
    int busy_n;
    int cyc;
    logic [31:0] hi0;
    logic [31:0] lo0;
    hi0 = hi;
    lo0 = lo;
    mdStart = 1'b1;
    mdOperation = op;
    operandA = a;
    operandB = b;
    exp_q.push_back(model(op, a, b));
    #1 check("busy_c0", {63'd0, mdBusy}, 64'd1);
    @(negedge clk);
    mdStart = 1'b0;
    mdOperation = 3'b110;
    operandA = $urandom;
    operandB = $urandom;
    busy_n = 1;
    cyc = 1;
    while (!mdDone && cyc < 100) begin
      if (mdBusy) busy_n++;
      if (cyc == exp_lat / 2) begin
        check("hold_hi", {32'd0, hi}, {32'd0, hi0});
        check("hold_lo", {32'd0, lo}, {32'd0, lo0});
      end
      @(negedge clk);
      cyc++;
    end
    check("done_cycle", cyc, exp_lat);
    check("busy_len", busy_n, exp_lat);
    check("busy_at_done", {63'd0, mdBusy}, 64'd0);
  endtask

  task automatic do_mt(input logic [2:0] op, input logic [31:0] a);
    mdStart = 1'b1;
    mdOperation = op;
    operandA = a;
    operandB = $urandom;
    #1 check("mt_busy", {63'd0, mdBusy}, 64'd0);
    @(negedge clk);
    mdStart = 1'b0;
    mdOperation = 3'b110;
    if (op == 3'b100) check("mthi", {32'd0, hi}, {32'd0, a});
    else check("mtlo", {32'd0, lo}, {32'd0, a});
    check("mt_no_done", {63'd0, mdDone}, 64'd0);
  endtask

  // Starts a MULT 5x5 and returns in cycle C1.
  task automatic start_mult55();
    mdStart = 1'b1;
    mdOperation = 3'b000;
    operandA = 32'd5;
    operandB = 32'd5;
    #1 check("abort_busy_c0", {63'd0, mdBusy}, 64'd1);
    @(negedge clk);
    mdStart = 1'b0;
    mdOperation = 3'b110;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    rst_n = 1'b0;
    mdStart = 1'b0;
    mdOperation = 3'b110;
    operandA = 32'd0;
    operandB = 32'd0;
    cancel = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    check("rst_busy", {63'd0, mdBusy}, 64'd0);
    check("rst_done", {63'd0, mdDone}, 64'd0);
    check("rst_state", {62'd0, state_dbg}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(3'b000, 32'hFFFFFFFD, 32'd7, 34);
    check("mult_neg_hi", {32'd0, hi}, 64'hFFFFFFFF);
    check("mult_neg_lo", {32'd0, lo}, 64'hFFFFFFEB);
    do_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
    check("multu_max_hi", {32'd0, hi}, 64'hFFFFFFFE);
    check("multu_max_lo", {32'd0, lo}, 64'h00000001);
    do_op(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
    check("mult_m1_hi", {32'd0, hi}, 64'h0);
    check("mult_m1_lo", {32'd0, lo}, 64'h1);
    do_op(3'b010, 32'hFFFFFFF9, 32'd2, 34);
    check("div_neg_lo", {32'd0, lo}, 64'hFFFFFFFD);
    check("div_neg_hi", {32'd0, hi}, 64'hFFFFFFFF);
    do_op(3'b010, 32'h80000000, 32'hFFFFFFFF, 34);
    check("div_ovf_lo", {32'd0, lo}, 64'h80000000);
    check("div_ovf_hi", {32'd0, hi}, 64'h0);
    do_op(3'b011, 32'd10, 32'd0, 2);
    check("divz_lo", {32'd0, lo}, 64'hFFFFFFFF);
    check("divz_hi", {32'd0, hi}, 64'h0000000A);
    do_op(3'b010, 32'hFFFFFFF0, 32'd0, 2);
    check("divz_s_hi", {32'd0, hi}, 64'hFFFFFFF0);

    // Random operations, each started back-to-back in the mdDone cycle of
    // the previous one.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] op;
      logic [31:0] a;
      logic [31:0] b;
      op = 3'($urandom_range(0, 3));
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 300)));
      do_op(op, a, b, (op[1] && b == 32'd0) ? 2 : 34);
    end

    // Preload HI/LO, then abort an operation with cancel.
    @(negedge clk);
    do_mt(3'b100, 32'h11111111);
    do_mt(3'b101, 32'h22222222);
    start_mult55();                 // now in C1
    repeat (9) @(negedge clk);      // C10
    cancel = 1'b1;
    #1 check("cancel_busy_c10", {63'd0, mdBusy}, 64'd1);
    @(negedge clk);                 // C11
    cancel = 1'b0;
    check("cancel_state", {62'd0, state_dbg}, 64'd0);
    check("cancel_busy_c11", {63'd0, mdBusy}, 64'd0);
    check("cancel_hi", {32'd0, hi}, 64'h11111111);
    check("cancel_lo", {32'd0, lo}, 64'h22222222);
    d0 = done_seen;
    repeat (40) @(negedge clk);
    check("cancel_no_done", done_seen, d0);

    // Abort an operation with reset in C20.
    start_mult55();
    repeat (19) @(negedge clk);     // C20
    rst_n = 1'b0;
    #1;
    check("rstmid_hi", {32'd0, hi}, 64'h0);
    check("rstmid_lo", {32'd0, lo}, 64'h0);
    check("rstmid_busy", {63'd0, mdBusy}, 64'd0);
    check("rstmid_state", {62'd0, state_dbg}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    d0 = done_seen;
    repeat (40) @(negedge clk);
    check("rstmid_no_done", done_seen, d0);

    check("sb_leftover", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
